// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS encoding constants and types used by the instruction encoder
// and the control decoder. Holds the 6-bit opcode and funct values, the
// 4-bit operation enum used on the encoder's field interface, the error
// codes reported by the loader, and the loader FSM state type.
package mips_pkg;

   // Operation codes presented on the loader's in_op port; 11-15 are illegal
   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SLT  = 4'd4,
      OP_LW   = 4'd5,
      OP_SW   = 4'd6,
      OP_BEQ  = 4'd7,
      OP_BNE  = 4'd8,
      OP_J    = 4'd9,
      OP_ADDI = 4'd10
   } op_e;

   // Primary opcode field (bits 31:26)
   localparam logic [5:0] OPC_RTYPE = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   // R-type funct field (bits 5:0)
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   // Loader error codes
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0] ERR_OVERFLOW = 2'd2;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // R-type word with shamt forced to zero
   function automatic logic [31:0] rType(input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd,
                                          input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

   // I-type word; the immediate is passed through untouched
   function automatic logic [31:0] iType(input logic [5:0]  opc,
                                          input logic [4:0]  rs,
                                          input logic [4:0]  rt,
                                          input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/mips_field_packer.sv
// mips_field_packer
// Purely combinational packer: turns an operation code plus decoded register,
// immediate and jump-target fields into a 32-bit MIPS machine word.
// Ports:
//   i_op      4-bit operation code (mips_pkg::op_e values, 11-15 illegal)
//   i_rs/rt/rd register fields
//   i_imm     16-bit I-type immediate
//   i_target  26-bit J-type target
//   o_word    encoded machine word (zero when the op is illegal)
//   o_illegal high when i_op is not a supported operation
module mips_field_packer
   import mips_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [4:0]  i_rs,
   input  logic [4:0]  i_rt,
   input  logic [4:0]  i_rd,
   input  logic [15:0] i_imm,
   input  logic [25:0] i_target,
   output logic [31:0] o_word,
   output logic        o_illegal
);

   // Select the instruction format from the op; fields a format does not
   // use are simply left out of the word.
   always_comb begin
      o_word    = '0;
      o_illegal = 1'b0;
      case (i_op)
         OP_ADD:  o_word = rType(i_rs, i_rt, i_rd, FUNCT_ADD);
         OP_SUB:  o_word = rType(i_rs, i_rt, i_rd, FUNCT_SUB);
         OP_AND:  o_word = rType(i_rs, i_rt, i_rd, FUNCT_AND);
         OP_OR:   o_word = rType(i_rs, i_rt, i_rd, FUNCT_OR);
         OP_SLT:  o_word = rType(i_rs, i_rt, i_rd, FUNCT_SLT);
         OP_LW:   o_word = iType(OPC_LW,   i_rs, i_rt, i_imm);
         OP_SW:   o_word = iType(OPC_SW,   i_rs, i_rt, i_imm);
         OP_BEQ:  o_word = iType(OPC_BEQ,  i_rs, i_rt, i_imm);
         OP_BNE:  o_word = iType(OPC_BNE,  i_rs, i_rt, i_imm);
         OP_ADDI: o_word = iType(OPC_ADDI, i_rs, i_rt, i_imm);
         OP_J:    o_word = {OPC_J, i_target};
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Program loader in front of an instruction memory. Accepts a stream of
// decoded instruction fields over a valid/ready handshake, encodes each one
// and writes it to consecutive word addresses starting at 0.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               begin a load session (ignored while loading)
//   in_valid/in_ready   field-bundle handshake; ready only in LOAD
//   in_op, in_rs, in_rt, in_rd, in_imm, in_target, in_last  field bundle
//   imem_we/addr/wdata  registered instruction-memory write port
//   busy, done          LOAD / DONE state flags
//   err_code            0 none, 1 illegal op, 2 memory overflow
//   count               words written during the current session
module mips_instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_W = 8
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   count
);

   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e              r_state;
   state_e              w_nextState;
   logic [ADDR_W-1:0]   r_addrCnt;
   logic [ADDR_W:0]     r_count;
   logic [1:0]          r_errCode;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [31:0]         w_word;
   logic                w_illegal;
   logic                w_accept;
   logic                w_write;
   logic                w_atEnd;
   logic                w_restart;

   mips_field_packer u_packer (
      .i_op      (in_op),
      .i_rs      (in_rs),
      .i_rt      (in_rt),
      .i_rd      (in_rd),
      .i_imm     (in_imm),
      .i_target  (in_target),
      .o_word    (w_word),
      .o_illegal (w_illegal)
   );

   assign w_accept  = in_valid && (r_state == ST_LOAD);
   assign w_write   = w_accept && !w_illegal;
   assign w_atEnd   = (r_addrCnt == {ADDR_W{1'b1}});
   assign w_restart = start && (r_state != ST_LOAD);

   // Next-state logic. An illegal op ends the session with an error; a legal
   // word either finishes the session (in_last) or, if it just filled the
   // last memory word, ends it with an overflow error.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_LOAD: begin
            if (w_accept) begin
               if (w_illegal)
                  w_nextState = ST_ERR;
               else if (in_last)
                  w_nextState = ST_DONE;
               else if (w_atEnd)
                  w_nextState = ST_ERR;
            end
         end
         default: begin
            if (start)
               w_nextState = ST_LOAD;
         end
      endcase
   end

   // State register; reset takes priority over a simultaneous start.
   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_nextState;
   end

   // Address counter, word count, error code and the registered write port.
   // The write strobe is re-evaluated every cycle so it is high for exactly
   // one cycle per legal accept, while address/data hold their last values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addrCnt <= '0;
         r_count   <= '0;
         r_errCode <= ERR_NONE;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
      end else begin
         r_we <= w_write;
         if (w_restart) begin
            r_addrCnt <= '0;
            r_count   <= '0;
            r_errCode <= ERR_NONE;
         end
         if (w_write) begin
            r_addr    <= r_addrCnt;
            r_wdata   <= w_word;
            r_addrCnt <= r_addrCnt + ADDR_ONE;
            r_count   <= r_count + COUNT_ONE;
            if (!in_last && w_atEnd)
               r_errCode <= ERR_OVERFLOW;
         end
         if (w_accept && w_illegal)
            r_errCode <= ERR_ILLEGAL;
      end
   end

   assign in_ready   = (r_state == ST_LOAD);
   assign busy       = (r_state == ST_LOAD);
   assign done       = (r_state == ST_DONE);
   assign err_code   = r_errCode;
   assign count      = r_count;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb_mips_instr_encoder
// Self-checking bench for the MIPS program loader: a table of directed
// vectors with hand-computed words, hand-written error/reset/overflow
// sequences, and randomized traffic checked every cycle against a
// behavioural model of the loader.
module tb_mips_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   typedef struct {
      bit          start;
      bit          valid;
      int          op;
      int          rs;
      int          rt;
      int          rd;
      int          imm;
      int          target;
      bit          last;
      bit          expWe;
      int          expAddr;
      logic [31:0] expData;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              inValid;
   logic              inReady;
   logic [3:0]        inOp;
   logic [4:0]        inRs;
   logic [4:0]        inRt;
   logic [4:0]        inRd;
   logic [15:0]       inImm;
   logic [25:0]       inTarget;
   logic              inLast;
   logic              imemWe;
   logic [ADDR_W-1:0] imemAddr;
   logic [31:0]       imemWdata;
   logic              busy;
   logic              done;
   logic [1:0]        errCode;
   logic [ADDR_W:0]   count;

   int compCount = 0;
   int failCount = 0;

   // Behavioural model state
   int          mState = M_IDLE;
   int          mAddr  = 0;
   int          mCount = 0;
   int          mErr   = 0;
   bit          expWe  = 1'b0;
   int          expAddr = 0;
   logic [31:0] expData = '0;

   vec_t vecs[$];

   mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (inValid),
      .in_ready   (inReady),
      .in_op      (inOp),
      .in_rs      (inRs),
      .in_rt      (inRt),
      .in_rd      (inRd),
      .in_imm     (inImm),
      .in_target  (inTarget),
      .in_last    (inLast),
      .imem_we    (imemWe),
      .imem_addr  (imemAddr),
      .imem_wdata (imemWdata),
      .busy       (busy),
      .done       (done),
      .err_code   (errCode),
      .count      (count)
   );

   always #5 clk = ~clk;

   // Reference encoding built from the textbook field positions
   function automatic logic [31:0] refEncode(int op, int rs, int rt, int rd, int imm, int target);
      longint w;
      int functs[5] = '{32, 34, 36, 37, 42};
      int opc;
      if (op <= 4) begin
         w = longint'(rs) * (64'd1 << 21) + longint'(rt) * (64'd1 << 16)
           + longint'(rd) * (64'd1 << 11) + longint'(functs[op]);
      end else if (op == 9) begin
         w = longint'(2) * (64'd1 << 26) + longint'(target);
      end else begin
         case (op)
            5:       opc = 35;
            6:       opc = 43;
            7:       opc = 4;
            8:       opc = 5;
            default: opc = 8;
         endcase
         w = longint'(opc) * (64'd1 << 26) + longint'(rs) * (64'd1 << 21)
           + longint'(rt) * (64'd1 << 16) + longint'(imm);
      end
      return w[31:0];
   endfunction

   function automatic vec_t mkVec(bit st, bit va, int op, int rs, int rt, int rd,
                                  int imm, int tg, bit la, bit ew, int ea, logic [31:0] ed);
      vec_t v;
      v.start = st; v.valid = va; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd;
      v.imm = imm; v.target = tg; v.last = la; v.expWe = ew; v.expAddr = ea; v.expData = ed;
      return v;
   endfunction

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      compCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(vec_t v);
      start    = v.start;
      inValid  = v.valid;
      inOp     = v.op[3:0];
      inRs     = v.rs[4:0];
      inRt     = v.rt[4:0];
      inRd     = v.rd[4:0];
      inImm    = v.imm[15:0];
      inTarget = v.target[25:0];
      inLast   = v.last;
   endtask

   // Advance the model by one clock edge using the inputs seen at that edge
   task automatic modelUpdate();
      if (reset) begin
         mState = M_IDLE; mAddr = 0; mCount = 0; mErr = 0;
         expWe = 1'b0; expAddr = 0; expData = '0;
      end else begin
         expWe = 1'b0;
         if (mState == M_LOAD) begin
            if (inValid) begin
               if (inOp > 4'd10) begin
                  mState = M_ERR;
                  mErr   = 1;
               end else begin
                  expWe   = 1'b1;
                  expAddr = mAddr;
                  expData = refEncode(int'(inOp), int'(inRs), int'(inRt), int'(inRd),
                                      int'(inImm), int'(inTarget));
                  mCount++;
                  if (inLast)
                     mState = M_DONE;
                  else if (mAddr == DEPTH - 1) begin
                     mState = M_ERR;
                     mErr   = 2;
                  end
                  mAddr = (mAddr + 1) % DEPTH;
               end
            end
         end else if (start) begin
            mState = M_LOAD; mAddr = 0; mCount = 0; mErr = 0;
         end
      end
   endtask

   // One clock: update the model at the rising edge, compare at the falling edge
   task automatic stepCycle();
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      checkOutput("we",    32'(imemWe),    32'(expWe));
      checkOutput("addr",  32'(imemAddr),  expAddr);
      checkOutput("wdata", imemWdata,      expData);
      checkOutput("ready", 32'(inReady),   32'(mState == M_LOAD));
      checkOutput("busy",  32'(busy),      32'(mState == M_LOAD));
      checkOutput("done",  32'(done),      32'(mState == M_DONE));
      checkOutput("err",   32'(errCode),   mErr);
      checkOutput("count", 32'(count),     mCount);
   endtask

   task automatic idle();
      applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
   endtask

   initial begin
      reset = 1'b1;
      idle();

      // Directed vectors: {start, valid, op, rs, rt, rd, imm, target, last, expWe, expAddr, expData}
      vecs.push_back(mkVec(1, 0, 0,  0, 0, 0, 0,      0,    0, 0, 0, 32'h0));
      vecs.push_back(mkVec(0, 1, 0,  1, 2, 3, 0,      0,    1, 1, 0, 32'h00221820));
      vecs.push_back(mkVec(0, 0, 0,  0, 0, 0, 0,      0,    0, 0, 0, 32'h0));
      vecs.push_back(mkVec(1, 0, 0,  0, 0, 0, 0,      0,    0, 0, 0, 32'h0));
      vecs.push_back(mkVec(0, 1, 5, 29, 8, 0, 4,      0,    0, 1, 0, 32'h8FA80004));
      vecs.push_back(mkVec(0, 1, 6, 29, 8, 0, 4,      0,    0, 1, 1, 32'hAFA80004));
      vecs.push_back(mkVec(0, 1, 10, 0, 9, 0, 16'hFFFF, 0,  0, 1, 2, 32'h2009FFFF));
      vecs.push_back(mkVec(0, 1, 9,  0, 0, 0, 0,      16'h10, 1, 1, 3, 32'h08000010));
      vecs.push_back(mkVec(1, 0, 0,  0, 0, 0, 0,      0,    0, 0, 0, 32'h0));
      vecs.push_back(mkVec(0, 1, 7,  4, 5, 0, 16'h0010, 0,  0, 1, 0, 32'h10850010));
      vecs.push_back(mkVec(0, 0, 15, 1, 1, 1, 0,      0,    0, 0, 0, 32'h0));
      vecs.push_back(mkVec(0, 0, 15, 1, 1, 1, 0,      0,    1, 0, 0, 32'h0));
      vecs.push_back(mkVec(0, 1, 8,  6, 7, 0, 16'hFFFE, 0,  0, 1, 1, 32'h14C7FFFE));
      vecs.push_back(mkVec(0, 1, 1, 10, 11, 12, 0,    0,    1, 1, 2, 32'h014B6022));

      // Reset state
      stepCycle();
      stepCycle();
      checkOutput("rst_we",    32'(imemWe),    0);
      checkOutput("rst_addr",  32'(imemAddr),  0);
      checkOutput("rst_wdata", imemWdata,      0);
      checkOutput("rst_ready", 32'(inReady),   0);
      checkOutput("rst_count", 32'(count),     0);
      reset = 1'b0;
      stepCycle();

      $display("[TB] directed vector table");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         stepCycle();
         checkOutput($sformatf("tbl%0d_we", i), 32'(imemWe), 32'(vecs[i].expWe));
         if (vecs[i].expWe) begin
            checkOutput($sformatf("tbl%0d_addr", i), 32'(imemAddr), vecs[i].expAddr);
            checkOutput($sformatf("tbl%0d_data", i), imemWdata, vecs[i].expData);
         end
      end
      idle();
      stepCycle();
      checkOutput("tbl_done",  32'(done),    1);
      checkOutput("tbl_count", 32'(count),   3);
      checkOutput("tbl_ready", 32'(inReady), 0);

      $display("[TB] illegal op sequence");
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0)); stepCycle();
      applyStimulus(mkVec(0, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, '0)); stepCycle();
      checkOutput("ill_w0", imemWdata, 32'h00221820);
      applyStimulus(mkVec(0, 1, 3, 3, 4, 5, 0, 0, 0, 0, 0, '0)); stepCycle();
      checkOutput("ill_a1", 32'(imemAddr), 1);
      checkOutput("ill_w1", imemWdata, 32'h00642825);
      applyStimulus(mkVec(0, 1, 12, 1, 1, 1, 0, 0, 0, 0, 0, '0)); stepCycle();
      checkOutput("ill_we",    32'(imemWe),  0);
      checkOutput("ill_err",   32'(errCode), 1);
      checkOutput("ill_count", 32'(count),   2);
      checkOutput("ill_ready", 32'(inReady), 0);
      applyStimulus(mkVec(0, 1, 0, 1, 2, 3, 0, 0, 1, 0, 0, '0)); stepCycle();
      checkOutput("ill_noacc", 32'(imemWe), 0);
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0)); stepCycle();
      checkOutput("ill_clr", 32'(errCode), 0);
      applyStimulus(mkVec(0, 1, 4, 7, 8, 9, 0, 0, 1, 0, 0, '0)); stepCycle();
      checkOutput("ill_re_we",   32'(imemWe),   1);
      checkOutput("ill_re_addr", 32'(imemAddr), 0);
      checkOutput("ill_re_data", imemWdata,     32'h00E8482A);
      checkOutput("ill_re_done", 32'(done),     1);
      idle(); stepCycle();

      $display("[TB] reset during session");
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0)); stepCycle();
      applyStimulus(mkVec(0, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, '0)); stepCycle();
      applyStimulus(mkVec(0, 1, 1, 5, 6, 7, 0, 0, 0, 0, 0, '0));
      reset = 1'b1;
      stepCycle();
      checkOutput("mid_we",    32'(imemWe),   0);
      checkOutput("mid_addr",  32'(imemAddr), 0);
      checkOutput("mid_wdata", imemWdata,     0);
      checkOutput("mid_count", 32'(count),    0);
      checkOutput("mid_busy",  32'(busy),     0);
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0));
      stepCycle();
      checkOutput("rststart_ready", 32'(inReady), 0);
      reset = 1'b0;
      idle(); stepCycle();

      $display("[TB] random fill to overflow");
      applyStimulus(mkVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0)); stepCycle();
      for (int c = 0; c < 3000 && mCount < DEPTH; c++) begin
         applyStimulus(mkVec(0, $urandom_range(0, 3) != 0, $urandom_range(0, 10),
                             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 65535), int'($urandom_range(0, 32'h3FFFFFF)),
                             0, 0, 0, '0));
         stepCycle();
      end
      checkOutput("ovf_we",    32'(imemWe),   1);
      checkOutput("ovf_addr",  32'(imemAddr), DEPTH - 1);
      checkOutput("ovf_err",   32'(errCode),  2);
      checkOutput("ovf_count", 32'(count),    DEPTH);
      applyStimulus(mkVec(0, 1, 0, 1, 2, 3, 0, 0, 0, 0, 0, '0)); stepCycle();
      checkOutput("ovf_noacc", 32'(imemWe),   0);
      checkOutput("ovf_hold",  32'(count),    DEPTH);
      checkOutput("ovf_ready", 32'(inReady),  0);

      $display("[TB] random mixed traffic");
      for (int c = 0; c < 600; c++) begin
         int op;
         op = ($urandom_range(0, 15) == 0) ? $urandom_range(11, 15) : $urandom_range(0, 10);
         applyStimulus(mkVec($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, op,
                             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                             $urandom_range(0, 65535), int'($urandom_range(0, 32'h3FFFFFF)),
                             $urandom_range(0, 15) == 0, 0, 0, '0));
         reset = ($urandom_range(0, 63) == 0);
         stepCycle();
      end
      reset = 1'b0;
      idle(); stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
      $finish;
   end

endmodule
